// File: rtl/alu_share_arbiter.sv
// Shares one structural_ALU_1 between two requesters with a req/gnt/done handshake.
// Define ALU_ARB_RR_EN for round-robin arbitration; default build is fixed priority (req0 first).

module structural_ALU_1 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c,
  input  logic [2:0]  op,
  output logic [15:0] w,
  output logic        neg,
  output logic        zer
);
  logic [15:0] b_sel;
  logic [15:0] sum;

  // op 1 reuses the adder with inverted B: a + ~b + c, so c=1 gives a - b
  assign b_sel = (op == 3'd1) ? ~b : b;
  assign sum   = a + b_sel + {15'd0, c};

  always_comb begin
    w = '0;
    unique case (op)
      3'd0, 3'd1: w = sum;
      3'd2:       w = a & b;
      3'd3:       w = a | b;
      3'd4:       w = a ^ b;
      3'd5:       w = ~a;
      3'd6:       w = {a[14:0], c};
      3'd7:       w = {c, a[15:1]};
      default:    w = '0;
    endcase
  end

  assign neg = w[15];
  assign zer = (w == '0);
endmodule

module alu_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             c0,
  input  logic             c1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             neg,
  output logic             zer,
  output logic             busy,
  output logic [CNT_W-1:0] op_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             c_q;
  logic [2:0]       op_q;
  logic             owner_q;
  logic             win1;
  logic             take;
  logic [WIDTH-1:0] alu_w;
  logic             alu_neg, alu_zer;

`ifdef ALU_ARB_RR_EN
  logic last_q;
  // on a tie the requester that did not win last time is served
  assign win1 = req1 & (~req0 | ~last_q);
`else
  assign win1 = req1 & ~req0;
`endif

  assign take = (state_q == IDLE) & (req0 | req1);
  assign busy = (state_q != IDLE);

  structural_ALU_1 u_alu (
    .a   (a_q),
    .b   (b_q),
    .c   (c_q),
    .op  (op_q),
    .w   (alu_w),
    .neg (alu_neg),
    .zer (alu_zer)
  );

  // handshake pulses are masked while rst is high so an aborted transaction shows nothing
  always_comb begin
    state_nxt = state_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_nxt = EXEC;
          gnt0      = ~rst & ~win1;
          gnt1      = ~rst & win1;
        end
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        done0     = ~rst & ~owner_q;
        done1     = ~rst & owner_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      op_q    <= '0;
      owner_q <= 1'b0;
      res     <= '0;
      neg     <= 1'b0;
      zer     <= 1'b0;
      op_cnt  <= '0;
`ifdef ALU_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_nxt;
      if (take) begin
        a_q     <= win1 ? a1 : a0;
        b_q     <= win1 ? b1 : b0;
        c_q     <= win1 ? c1 : c0;
        op_q    <= win1 ? op1 : op0;
        owner_q <= win1;
`ifdef ALU_ARB_RR_EN
        last_q  <= win1;
`endif
      end
      if (state_q == EXEC) begin
        res <= alu_w;
        neg <= alu_neg;
        zer <= alu_zer;
      end
      if (state_q == DONE) op_cnt <= op_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequences one shared `structural_ALU_1` instance between two independent requesters. Each transaction uses a request/grant/done handshake. The block latches the winner's operands and holds them on the ALU for one evaluation cycle. It then registers `W`/`neg`/`zer` and returns them to the granted requester with a one-cycle done pulse. It sits between the two operand-producing units and the ALU datapath; nothing else drives the ALU.

## Interface
Parameters:
- `WIDTH`, 16, operand/result width; fixed at 16 to match `structural_ALU_1`.
- `CNT_W`, 8, width of the completed-operation counter.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request from requester 0 / 1.
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands of requester 0 / 1.
- `c0`, `c1`  in  1  carry-in of requester 0 / 1.
- `op0`, `op1`  in  3  ALU opcode of requester 0 / 1.
- `gnt0`, `gnt1`  out  1  one-cycle accept pulse; operands sampled this cycle.
- `done0`, `done1`  out  1  one-cycle result-valid pulse.
- `res`  out  WIDTH  registered ALU result `W`.
- `neg`, `zer`  out  1  registered ALU flags.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `op_cnt`  out  CNT_W  count of completed operations.

## Operation
- FSM states: IDLE, EXEC, DONE. All transitions are unconditional except IDLE.
- IDLE, no request:
  - stays IDLE.
- IDLE, one or more requests:
  - choose the winner (see Configuration).
  - pulse `gnt<winner>`.
  - latch that requester's a/b/c/op into the operand registers.
  - record the owner.
  - go to EXEC.
- EXEC:
  - the ALU sees only the latched operand registers.
  - at the cycle's end, register `W`→`res`, `neg`, `zer`.
  - go to DONE.
- DONE:
  - pulse `done<owner>`.
  - increment `op_cnt`, wrapping from 2^CNT_W−1 to 0.
  - go to IDLE.
- `res`/`neg`/`zer` hold their value until the next EXEC capture.
- Requests seen while busy are ignored and get no grant. The requester keeps `req` high to be served later.
- A `req` that drops after its grant does not cancel the operation; `done` still pulses.
- A `req` still high in the DONE cycle is treated as a new request in the following IDLE cycle.
- The ALU input mux is driven only from registers, so requester input changes after the grant have no effect.

## Timing
- Grant at cycle t (IDLE).
- ALU evaluation at t+1 (EXEC).
- `done` and valid `res` at t+2 (DONE).
- Earliest next grant at t+3.
- Maximum throughput is 1 operation per 3 cycles; latency from grant to done is 2 cycles.
- At most one of `gnt0`/`gnt1`/`done0`/`done1` is high in any cycle.
- Reset values:
  - FSM IDLE.
  - `gnt*`, `done*`, `busy` = 0.
  - `res` = 16'h0000, `neg` = 0, `zer` = 0, `op_cnt` = 0.
  - operand registers 0.
  - last-winner pointer = 1, so requester 0 wins the first tie.
- Reset asserted in EXEC or DONE aborts the transaction: no `done` pulse, outputs forced to reset values in the next cycle.
- Reset has priority over every other event.

## Configuration
- Macro: `ALU_ARB_RR_EN`.
- Defined: round-robin arbitration.
  - When both requesters are active in IDLE, the requester not granted most recently wins.
  - The pointer updates on every grant.
  - A single requester always wins.
- Undefined: fixed priority; `req0` always beats `req1`. The pointer register is not built.
- The handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset, then a single request: `req0`=1, `a0`=16'h1234, `b0`=16'h0F0F, `c0`=0, `op0`=3'd0.
  - Required: `gnt0` at t, `done0` at t+2.
  - `res`/`neg`/`zer` equal a stand-alone `structural_ALU_1` driven with the same inputs.
  - `op_cnt`=1.
- Sweep `op0` over 0..7 with `a0`=$random and `b0`=$random, back-to-back.
  - Required: grants 3 cycles apart; each `res` matches a reference ALU; `op_cnt`=8 at the end.
- Both `req0` and `req1` held high for 4 operations.
  - With `ALU_ARB_RR_EN`: grant order 0,1,0,1.
  - Without it: grant order 0,0,0,0.
- Change `a0` and drop `req0` in the cycle after `gnt0`.
  - Required: `res` reflects the originally latched operands; `done0` still pulses.
- Assert `rst` during EXEC.
  - Required: no `done` pulse; next cycle `res`=0, `busy`=0, `op_cnt`=0; the next request is granted normally.
- Set `CNT_W`=2 and run 5 operations.
  - Required: `op_cnt` sequence 1,2,3,0,1.
